aclock_multi: RTL and testbench

- Parametrised successor to the single-alarm clock: a 24-hour BCD HH:MM:SS clock with N independently programmable alarms, snooze and a ring timeout.
- Seconds are derived from the system clock by a programmable prescaler.
- Sits at the same level as the single-alarm clock; its outputs drive the 7-segment display and the buzzer logic.

---
 rtl/aclock_multi_pkg.sv | 48 ++++
 rtl/aclock_multi_time.sv | 77 +++++++
 rtl/aclock_multi.sv | 150 +++++++++++++++
 tb/tb_aclock_multi.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/aclock_multi_pkg.sv
// Shared BCD limits, FSM encoding and HH:MM helpers for the multi-alarm clock.
package aclock_multi_pkg;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hm_t;

  function automatic logic hm_valid(hm_t t);
    int h;
    int m;
    h = int'(t.h1) * 10 + int'(t.h0);
    m = int'(t.m1) * 10 + int'(t.m0);
    return (t.h0 <= 4'd9) && (t.m1 <= 4'd9) && (t.m0 <= 4'd9) &&
           (h <= HOUR_MAX) && (m <= MIN_MAX);
  endfunction

  // Adds minutes to a valid HH:MM, wrapping past 23:59.
  function automatic hm_t hm_add_min(hm_t t, int add);
    int   total;
    int   h;
    int   m;
    hm_t  r;
    total = (int'(t.h1) * 10 + int'(t.h0)) * (MIN_MAX + 1) +
            int'(t.m1) * 10 + int'(t.m0) + add;
    total = total % ((HOUR_MAX + 1) * (MIN_MAX + 1));
    h = total / (MIN_MAX + 1);
    m = total % (MIN_MAX + 1);
    r.h1 = 2'(h / 10);
    r.h0 = 4'(h % 10);
    r.m1 = 4'(m / 10);
    r.m0 = 4'(m % 10);
    return r;
  endfunction

endpackage

// File: rtl/aclock_multi_time.sv
// Prescaled BCD HH:MM:SS counter with validated load; min_tick_o marks the cycle
// where seconds have just rolled to 00 by counting (never by a load).
module bcd_time_counter
  import aclock_multi_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_i,
  input  hm_t        ld_hm_i,
  output hm_t        hm_o,
  output logic [3:0] s1_o,
  output logic [3:0] s0_o,
  output logic       sec_tick_o,
  output logic       min_tick_o
);

  localparam int CW = $clog2(TICKS_PER_SEC);

  logic [CW-1:0] cnt_q, cnt_d;
  hm_t           hm_q, hm_d;
  logic [3:0]    s1_q, s1_d, s0_q, s0_d;
  logic          min_q, min_d;
  logic          ld_ok;

  always_comb begin
    ld_ok      = hm_valid(ld_hm_i);
    sec_tick_o = (cnt_q == CW'(TICKS_PER_SEC - 1));
    cnt_d      = sec_tick_o ? '0 : cnt_q + 1'b1;
    hm_d       = hm_q;
    s1_d       = s1_q;
    s0_d       = s0_q;
    min_d      = 1'b0;
    if (ld_i && ld_ok) begin
      hm_d  = ld_hm_i;
      s1_d  = '0;
      s0_d  = '0;
      cnt_d = '0;
    end else if (sec_tick_o) begin
      if (s0_q != 4'(SEC_MAX % 10)) begin
        s0_d = s0_q + 4'd1;
      end else begin
        s0_d = '0;
        if (s1_q != 4'(SEC_MAX / 10)) begin
          s1_d = s1_q + 4'd1;
        end else begin
          s1_d  = '0;
          min_d = 1'b1;
          hm_d  = hm_add_min(hm_q, 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hm_q  <= ld_ok ? ld_hm_i : '0;
      s1_q  <= '0;
      s0_q  <= '0;
      min_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hm_q  <= hm_d;
      s1_q  <= s1_d;
      s0_q  <= s0_d;
      min_q <= min_d;
    end
  end

  assign hm_o       = hm_q;
  assign s1_o       = s1_q;
  assign s0_o       = s0_q;
  assign min_tick_o = min_q;

endmodule

// File: rtl/aclock_multi.sv
// 24h BCD clock with N programmable alarms, snooze and ring timeout.
// Alarm/Alarm_id are registered; they follow the matching HH:MM:00 by one clk.
module aclock_multi
  import aclock_multi_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  parameter int N_ALARMS      = 4,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_SEC      = 60,
  localparam int AW           = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          H_in1,
  input  logic [3:0]          H_in0,
  input  logic [3:0]          M_in1,
  input  logic [3:0]          M_in0,
  input  logic                LD_time,
  input  logic                LD_alarm,
  input  logic [AW-1:0]       AL_SEL,
  input  logic [N_ALARMS-1:0] AL_EN,
  input  logic                STOP_al,
  input  logic                SNOOZE,
  output logic                Alarm,
  output logic [AW-1:0]       Alarm_id,
  output logic [1:0]          H_out1,
  output logic [3:0]          H_out0,
  output logic [3:0]          M_out1,
  output logic [3:0]          M_out0,
  output logic [3:0]          S_out1,
  output logic [3:0]          S_out0
);

  hm_t           hm_in;
  hm_t           now_hm;
  logic          sec_tick;
  logic          min_tick;
  hm_t           slot_q [N_ALARMS];
  hm_t           snz_q;
  state_e        state_q;
  logic          alarm_q;
  logic [AW-1:0] id_q;
  logic [7:0]    ring_q;
  logic          match_any;
  logic [AW-1:0] match_idx;
  logic          snz_hit;
  logic          en_cur;
  logic          al_ok;

  assign hm_in = {H_in1, H_in0, M_in1, M_in0};

  bcd_time_counter #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_time (
    .clk       (clk),
    .reset     (reset),
    .ld_i      (LD_time),
    .ld_hm_i   (hm_in),
    .hm_o      (now_hm),
    .s1_o      (S_out1),
    .s0_o      (S_out0),
    .sec_tick_o(sec_tick),
    .min_tick_o(min_tick)
  );

  // Descending scan so the lowest matching slot index is the one kept.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (min_tick && AL_EN[k] && (slot_q[k] == now_hm)) begin
        match_any = 1'b1;
        match_idx = AW'(k);
      end
    end
    snz_hit = min_tick && (now_hm == snz_q);
    en_cur  = AL_EN[id_q];
    al_ok   = hm_valid(hm_in) && (int'(AL_SEL) < N_ALARMS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_ALARMS; k++) slot_q[k] <= '0;
    end else if (LD_alarm && al_ok) begin
      slot_q[AL_SEL] <= hm_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      alarm_q <= 1'b0;
      id_q    <= '0;
      ring_q  <= '0;
      snz_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match_any) begin
            state_q <= RINGING;
            alarm_q <= 1'b1;
            id_q    <= match_idx;
            ring_q  <= '0;
          end
        end
        RINGING: begin
          if (STOP_al || !en_cur) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
          end else if (SNOOZE) begin
            state_q <= SNOOZED;
            alarm_q <= 1'b0;
            snz_q   <= hm_add_min(now_hm, SNOOZE_MIN);
          end else if (sec_tick) begin
            if (ring_q == 8'(RING_SEC - 1)) begin
              state_q <= IDLE;
              alarm_q <= 1'b0;
            end else begin
              ring_q <= ring_q + 8'd1;
            end
          end
        end
        SNOOZED: begin
          if (STOP_al || !en_cur) begin
            state_q <= IDLE;
          end else if (match_any) begin
            state_q <= RINGING;
            alarm_q <= 1'b1;
            id_q    <= match_idx;
            ring_q  <= '0;
          end else if (snz_hit) begin
            state_q <= RINGING;
            alarm_q <= 1'b1;
            ring_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign Alarm    = alarm_q;
  assign Alarm_id = id_q;
  assign H_out1   = now_hm.h1;
  assign H_out0   = now_hm.h0;
  assign M_out1   = now_hm.m1;
  assign M_out0   = now_hm.m0;

endmodule

// File: tb/tb_aclock_multi.sv
// Directed bench for aclock_multi: expected outputs queued at stimulus, compared at output time.
module tb_aclock_multi;

  localparam int N  = 5;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic [1:0]    H_in1;
  logic [3:0]    H_in0, M_in1, M_in0;
  logic          LD_time, LD_alarm;
  logic [AW-1:0] AL_SEL;
  logic [N-1:0]  AL_EN;
  logic          STOP_al, SNOOZE;
  logic          Alarm;
  logic [AW-1:0] Alarm_id;
  logic [1:0]    H_out1;
  logic [3:0]    H_out0, M_out1, M_out0, S_out1, S_out0;

  typedef struct {
    string       tag;
    logic [25:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   nerr = 0;
  int   nchk = 0;

  aclock_multi #(
    .TICKS_PER_SEC(10), .N_ALARMS(N), .SNOOZE_MIN(5), .RING_SEC(60)
  ) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_SEL(AL_SEL), .AL_EN(AL_EN),
    .STOP_al(STOP_al), .SNOOZE(SNOOZE),
    .Alarm(Alarm), .Alarm_id(Alarm_id),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] pk(bit a, int id, int h, int m, int s);
    return {a, 3'(id), 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic expect_o(string tag, bit a, int id, int h, int m, int s);
    exp_t e;
    e.tag = tag;
    e.val = pk(a, id, h, m, s);
    exp_q.push_back(e);
  endtask

  task automatic check_o();
    exp_t        e;
    logic [25:0] got;
    e   = exp_q.pop_front();
    got = {Alarm, Alarm_id, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    nchk++;
    assert (got === e.val) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", e.tag, got, e.val);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_hm(int h1, int h0, int m1, int m0);
    H_in1 = 2'(h1); H_in0 = 4'(h0); M_in1 = 4'(m1); M_in0 = 4'(m0);
  endtask

  task automatic ld_time_raw(int h1, int h0, int m1, int m0);
    drive_hm(h1, h0, m1, m0);
    LD_time = 1'b1;
    step(1);
    LD_time = 1'b0;
  endtask

  task automatic load_time(int h, int m);
    ld_time_raw(h / 10, h % 10, m / 10, m % 10);
  endtask

  task automatic load_alarm(int sel, int h, int m);
    drive_hm(h / 10, h % 10, m / 10, m % 10);
    AL_SEL   = 3'(sel);
    LD_alarm = 1'b1;
    step(1);
    LD_alarm = 1'b0;
  endtask

  task automatic pulse_stop();
    STOP_al = 1'b1; step(1); STOP_al = 1'b0;
  endtask

  task automatic pulse_snooze();
    SNOOZE = 1'b1; step(1); SNOOZE = 1'b0;
  endtask

  task automatic wait_alarm(bit lvl, int budget);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (Alarm === lvl) break;
    end
  endtask

  initial begin
    reset = 1'b1; LD_time = 1'b0; LD_alarm = 1'b0; AL_SEL = '0; AL_EN = '0;
    STOP_al = 1'b0; SNOOZE = 1'b0;
    drive_hm(1, 1, 2, 6);

    // Reset load and free running
    step(2);
    expect_o("reset_load", 0, 0, 11, 26, 0); check_o();
    reset = 1'b0;
    expect_o("count_599", 0, 0, 11, 26, 59); step(599); check_o();
    expect_o("count_600", 0, 0, 11, 27, 0);  step(1);   check_o();

    // Basic ring on slot 2
    load_alarm(2, 11, 30);
    AL_EN = 5'b00100;
    load_time(11, 29);
    expect_o("pre_ring_50s", 0, 0, 11, 29, 50); step(500); check_o();
    expect_o("ring_lag", 0, 0, 11, 30, 0);      step(100); check_o();
    expect_o("ring_rise", 1, 2, 11, 30, 0);     step(1);   check_o();
    expect_o("stop", 0, 2, 11, 30, 0);          pulse_stop(); check_o();

    // Snooze across midnight
    load_alarm(0, 23, 58);
    AL_EN = 5'b00001;
    load_time(23, 57);
    expect_o("snz_pre", 0, 2, 23, 58, 0);   step(600); check_o();
    expect_o("snz_ring", 1, 0, 23, 58, 0);  step(1);   check_o();
    expect_o("snz_press", 0, 0, 23, 58, 0); pulse_snooze(); check_o();
    expect_o("snz_wait", 0, 0, 0, 3, 0);    step(2998); check_o();
    expect_o("snz_fire", 1, 0, 0, 3, 0);    step(1);    check_o();
    expect_o("snz_stop", 0, 0, 0, 3, 0);    pulse_stop(); check_o();

    // Priority and ring timeout
    load_alarm(1, 7, 0);
    load_alarm(3, 7, 0);
    AL_EN = 5'b01010;
    load_time(6, 59);
    expect_o("prio_pre", 0, 0, 7, 0, 0);    step(600); check_o();
    expect_o("prio_ring", 1, 1, 7, 0, 0);   step(1);   check_o();
    expect_o("ring_59s", 1, 1, 7, 0, 59);   step(598); check_o();
    expect_o("timeout", 0, 1, 7, 1, 0);     wait_alarm(1'b0, 5); check_o();

    // Invalid loads
    expect_o("ld_h24", 0, 1, 7, 1, 0);      ld_time_raw(2, 4, 0, 0);  check_o();
    expect_o("ld_m10", 0, 1, 7, 1, 0);      ld_time_raw(1, 2, 3, 10); check_o();
    expect_o("ld_keeps_cnt", 0, 1, 7, 1, 1); step(8); check_o();
    load_alarm(5, 7, 2);
    AL_EN = 5'b11111;
    expect_o("sel_oob", 0, 1, 7, 2, 0);     step(590); check_o();

    // Edge cases
    load_alarm(0, 8, 0);
    load_time(8, 0);
    expect_o("ld_no_match", 0, 1, 8, 0, 0); step(2); check_o();
    load_alarm(4, 8, 1);
    expect_o("ring4", 1, 4, 8, 1, 0);       step(598); check_o();
    AL_EN = 5'b01111;
    expect_o("en_drop", 0, 4, 8, 1, 0);     step(1); check_o();
    AL_EN = 5'b11111;
    load_alarm(3, 8, 2);
    expect_o("ring3", 1, 3, 8, 2, 0);       step(598); check_o();
    expect_o("snz3", 0, 3, 8, 2, 0);        pulse_snooze(); check_o();
    drive_hm(0, 8, 0, 5);
    reset = 1'b1;
    expect_o("reset_snz", 0, 0, 8, 5, 0);   step(1); check_o();
    reset = 1'b0;
    expect_o("no_snz_fire", 0, 0, 8, 7, 0); step(1201); check_o();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
